// File: rtl/mem_pkg.sv
// Shared constants and types for the self-initialising RAM.
package mem_pkg;

    // Power-on pattern loaded after every reset; repeats every 8 words.
    localparam logic [7:0] INIT_TABLE [0:7] = '{
        8'hAA, 8'hF0, 8'h0F, 8'hCC, 8'hE7, 8'h18, 8'hB7, 8'hED
    };

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_BURST
    } state_t;

    // Table entry for a given word index (index taken modulo 8).
    function automatic logic [7:0] init_entry(input int unsigned idx);
        return INIT_TABLE[idx[2:0]];
    endfunction

endpackage

// File: rtl/sp_ram_sync.sv
// Single-port RAM with a registered read port (read-before-write).
module sp_ram_sync #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] q
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_q;

    // Write on request; read port always registers the old contents of addr.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
        r_q <= r_mem[addr];
    end

    assign q = r_q;

endmodule

// File: rtl/seq_init_ram.sv
// Synchronous single-port RAM that reloads the pattern table after every
// reset, then serves single reads/writes and auto-incrementing burst reads.
module seq_init_ram #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  we,
    input  logic                  burst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [ADDR_WIDTH-1:0] blen,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  ready,
    output logic                  rvalid,
    output logic [DATA_WIDTH-1:0] rdata
);

    import mem_pkg::*;

    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic [ADDR_WIDTH-1:0] r_baddr, w_baddr_nxt;
    logic [ADDR_WIDTH-1:0] r_bcnt, w_bcnt_nxt;
    logic                  r_rvalid, w_rvalid_nxt;
    logic [DATA_WIDTH-1:0] r_hold;

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_ram_we;
    logic [ADDR_WIDTH-1:0] w_ram_addr;
    logic [DATA_WIDTH-1:0] w_ram_wdata;
    logic [DATA_WIDTH-1:0] w_q;
    logic [DATA_WIDTH-1:0] w_init_word;

    // Table entry resized to the word width (zero-extend or keep LSBs).
    assign w_init_word = DATA_WIDTH'(init_entry(32'(r_cnt)));

    sp_ram_sync #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk  (clk),
        .we   (w_ram_we),
        .addr (w_ram_addr),
        .wdata(w_ram_wdata),
        .q    (w_q)
    );

    // State, counters and read-valid registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_INIT;
            r_cnt    <= '0;
            r_baddr  <= '0;
            r_bcnt   <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_baddr  <= w_baddr_nxt;
            r_bcnt   <= w_bcnt_nxt;
            r_rvalid <= w_rvalid_nxt;
        end
    end

    // Holds the last presented word so rdata is stable outside read cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold <= '0;
        end else if (r_rvalid) begin
            r_hold <= w_q;
        end
    end

    // Next-state logic and RAM port mux (init sequencer, burst, or host).
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_baddr_nxt  = r_baddr;
        w_bcnt_nxt   = r_bcnt;
        w_rvalid_nxt = 1'b0;
        w_ready      = 1'b0;
        w_accept     = 1'b0;
        w_ram_we     = 1'b0;
        w_ram_addr   = addr;
        w_ram_wdata  = wdata;

        case (r_state)
            ST_INIT: begin
                w_ram_we    = 1'b1;
                w_ram_addr  = r_cnt;
                w_ram_wdata = w_init_word;
                w_cnt_nxt   = r_cnt + ADDR_WIDTH'(1);
                if (r_cnt == '1) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                w_ready = 1'b1;
            end
            ST_BURST: begin
                if (r_bcnt != '0) begin
                    w_ram_addr   = r_baddr;
                    w_baddr_nxt  = r_baddr + ADDR_WIDTH'(1);
                    w_bcnt_nxt   = r_bcnt - ADDR_WIDTH'(1);
                    w_rvalid_nxt = 1'b1;
                end else begin
                    // Last word is on rdata now; behave as IDLE for new requests.
                    w_ready     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase

        // Nothing is accepted or written while reset is asserted.
        if (reset) begin
            w_ready  = 1'b0;
            w_ram_we = 1'b0;
        end

        w_accept = w_ready & req;
        if (w_accept) begin
            if (we) begin
                w_ram_we = 1'b1;
            end else begin
                w_rvalid_nxt = 1'b1;
                if (burst) begin
                    w_state_nxt = ST_BURST;
                    w_baddr_nxt = addr + ADDR_WIDTH'(1);
                    w_bcnt_nxt  = blen;
                end
            end
        end
    end

    assign ready  = w_ready;
    assign rvalid = r_rvalid;
    assign rdata  = r_rvalid ? w_q : r_hold;

endmodule

// File: tb/tb_seq_init_ram.sv
module tb_seq_init_ram;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: default geometry (8 x 8)
    logic       a_reset, a_req, a_we, a_burst;
    logic [2:0] a_addr, a_blen;
    logic [7:0] a_wdata;
    logic       a_ready, a_rvalid;
    logic [7:0] a_rdata;

    // DUT B: 16 x 12
    logic        b_reset, b_req, b_we, b_burst;
    logic [3:0]  b_addr, b_blen;
    logic [11:0] b_wdata;
    logic        b_ready, b_rvalid;
    logic [11:0] b_rdata;

    seq_init_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) u_a (
        .clk(clk), .reset(a_reset), .req(a_req), .we(a_we), .burst(a_burst),
        .addr(a_addr), .blen(a_blen), .wdata(a_wdata),
        .ready(a_ready), .rvalid(a_rvalid), .rdata(a_rdata)
    );

    seq_init_ram #(.DATA_WIDTH(12), .ADDR_WIDTH(4)) u_b (
        .clk(clk), .reset(b_reset), .req(b_req), .we(b_we), .burst(b_burst),
        .addr(b_addr), .blen(b_blen), .wdata(b_wdata),
        .ready(b_ready), .rvalid(b_rvalid), .rdata(b_rdata)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] tab [0:7] = '{8'hAA, 8'hF0, 8'h0F, 8'hCC, 8'hE7, 8'h18, 8'hB7, 8'hED};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_a(input logic [2:0] a);
        a_req = 1'b1; a_we = 1'b0; a_burst = 1'b0; a_addr = a;
        tick();
        a_req = 1'b0;
    endtask

    task automatic wr_a(input logic [2:0] a, input logic [7:0] d);
        a_req = 1'b1; a_we = 1'b1; a_burst = 1'b0; a_addr = a; a_wdata = d;
        tick();
        a_req = 1'b0; a_we = 1'b0;
    endtask

    task automatic burst_a(input logic [2:0] a, input logic [2:0] l);
        a_req = 1'b1; a_we = 1'b0; a_burst = 1'b1; a_addr = a; a_blen = l;
        tick();
        a_req = 1'b0; a_burst = 1'b0;
    endtask

    initial begin
        int n;
        int nv;
        logic [7:0] bw [0:3];

        a_reset = 1'b1; a_req = 1'b0; a_we = 1'b0; a_burst = 1'b0;
        a_addr = '0; a_blen = '0; a_wdata = '0;
        b_reset = 1'b1; b_req = 1'b0; b_we = 1'b0; b_burst = 1'b0;
        b_addr = '0; b_blen = '0; b_wdata = '0;

        // 1. reset values, init length, pattern readback
        tick(); tick();
        chk("rst_ready", 32'(a_ready), 32'd0);
        chk("rst_rvalid", 32'(a_rvalid), 32'd0);
        chk("rst_rdata", 32'(a_rdata), 32'd0);
        a_reset = 1'b0;
        n = 0;
        while (!a_ready && n < 40) begin
            tick();
            n++;
        end
        chk("init_len", 32'(n), 32'd8);

        a_req = 1'b1; a_we = 1'b0; a_burst = 1'b0; a_addr = 3'd0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("b2b_rvalid", 32'(a_rvalid), 32'd1);
            chk("b2b_rdata", 32'(a_rdata), 32'(tab[i]));
            if (i == 7) a_req = 1'b0;
            else a_addr = 3'(i + 1);
        end
        tick();
        chk("b2b_idle_rvalid", 32'(a_rvalid), 32'd0);

        // 2. write then read, neighbour unchanged, rdata hold
        wr_a(3'd3, 8'h5A);
        chk("wr_no_rvalid", 32'(a_rvalid), 32'd0);
        rd_a(3'd3);
        chk("rd_after_wr", 32'(a_rdata), 32'h5A);
        rd_a(3'd2);
        chk("neighbour", 32'(a_rdata), 32'h0F);
        tick();
        chk("idle_rvalid", 32'(a_rvalid), 32'd0);
        chk("rdata_hold", 32'(a_rdata), 32'h0F);

        // 3. burst with wrap, ready only on last word
        bw = '{8'hB7, 8'hED, 8'hAA, 8'hF0};
        burst_a(3'd6, 3'd3);
        for (int i = 0; i < 4; i++) begin
            chk("burst_rvalid", 32'(a_rvalid), 32'd1);
            chk("burst_rdata", 32'(a_rdata), 32'(bw[i]));
            chk("burst_ready", 32'(a_ready), (i == 3) ? 32'd1 : 32'd0);
            tick();
        end
        chk("burst_end_rvalid", 32'(a_rvalid), 32'd0);
        chk("burst_end_ready", 32'(a_ready), 32'd1);

        // single-word burst (blen=0)
        burst_a(3'd7, 3'd0);
        chk("burst1_rdata", 32'(a_rdata), 32'hED);
        chk("burst1_ready", 32'(a_ready), 32'd1);
        tick();
        chk("burst1_end_rvalid", 32'(a_rvalid), 32'd0);

        // 5a. write request during BURST is ignored
        burst_a(3'd0, 3'd2);
        a_req = 1'b1; a_we = 1'b1; a_addr = 3'd0; a_wdata = 8'h11;
        chk("bq_w0", 32'(a_rdata), 32'hAA);
        tick();
        chk("bq_w1", 32'(a_rdata), 32'hF0);
        a_req = 1'b0; a_we = 1'b0;
        tick();
        chk("bq_w2", 32'(a_rdata), 32'h0F);
        tick();
        chk("bq_no_extra_rvalid", 32'(a_rvalid), 32'd0);
        rd_a(3'd0);
        chk("bq_no_write", 32'(a_rdata), 32'hAA);

        // 4. reset during second word of a burst, re-init overwrites 0x5A
        wr_a(3'd3, 8'h5A);
        burst_a(3'd4, 3'd3);
        chk("rb_w0", 32'(a_rdata), 32'hE7);
        tick();
        chk("rb_w1", 32'(a_rdata), 32'h18);
        a_reset = 1'b1;
        tick();
        chk("rb_rvalid", 32'(a_rvalid), 32'd0);
        chk("rb_ready", 32'(a_ready), 32'd0);
        chk("rb_rdata", 32'(a_rdata), 32'd0);
        a_reset = 1'b0;

        // 5b. requests during INIT are ignored
        a_req = 1'b1; a_we = 1'b1; a_addr = 3'd0; a_wdata = 8'h77;
        n = 0; nv = 0;
        while (!a_ready && n < 40) begin
            tick();
            n++;
            if (a_rvalid) nv++;
            if (n == 4) a_we = 1'b0;
        end
        a_req = 1'b0; a_we = 1'b0;
        chk("reinit_len", 32'(n), 32'd8);
        chk("init_no_rvalid", 32'(nv), 32'd0);
        rd_a(3'd3);
        chk("reinit_addr3", 32'(a_rdata), 32'hCC);
        rd_a(3'd0);
        chk("init_no_write", 32'(a_rdata), 32'hAA);

        // 6. wider/deeper instance, reset held long
        chk("b_held_ready", 32'(b_ready), 32'd0);
        chk("b_held_rvalid", 32'(b_rvalid), 32'd0);
        chk("b_held_rdata", 32'(b_rdata), 32'd0);
        b_reset = 1'b0;
        n = 0;
        while (!b_ready && n < 40) begin
            tick();
            n++;
        end
        chk("b_init_len", 32'(n), 32'd16);
        b_req = 1'b1; b_we = 1'b0; b_addr = 4'd9;
        tick();
        chk("b_addr9", 32'(b_rdata), 32'h0F0);
        b_addr = 4'd15;
        tick();
        chk("b_addr15", 32'(b_rdata), 32'h0ED);
        b_addr = 4'd0;
        tick();
        chk("b_addr0", 32'(b_rdata), 32'h0AA);
        chk("b_rvalid", 32'(b_rvalid), 32'd1);
        b_req = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_init_ram.md
Name: seq_init_ram

Overview:
Parametrised successor to the async single-port ROM. It is a synchronous single-port RAM that loads itself with the standard 8-entry pattern table after every reset, using an internal sequencer. It supports single-word reads and writes with a registered read port. It also supports an auto-incrementing burst-read mode. It sits wherever the design previously used the fixed ROM but now needs run-time overwrite and streamed readout.

Parameters:
DATA_WIDTH, 8, word width in bits (≥1)
ADDR_WIDTH, 3, address width; depth = 2**ADDR_WIDTH (≥1)

Ports:
clk  in  1  system clock, rising-edge
reset  in  1  synchronous, active-high reset
req  in  1  request strobe; sampled only when ready=1
we  in  1  1 = write, 0 = read (qualified by req)
burst  in  1  1 = burst read (ignored when we=1)
addr  in  ADDR_WIDTH  word address / burst start address
blen  in  ADDR_WIDTH  burst length minus 1 (0 → 1 word, all-ones → full depth)
wdata  in  DATA_WIDTH  write data
ready  out  1  block can accept a request this cycle
rvalid  out  1  rdata holds valid read data this cycle
rdata  out  DATA_WIDTH  registered read data

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset). All state changes happen on the rising clk edge.
- Reset values: ready=0, rvalid=0, rdata=0. Reset sets state INIT and init counter = 0.
- Reset mid-operation (INIT, IDLE or BURST): the block aborts immediately, reloads state INIT and restarts the count from 0. No rvalid is produced from the aborted operation.
- Reset held for several cycles: the block stays at its reset values.
- FSM states: INIT, IDLE, BURST.
- INIT:
  - Each cycle writes mem[cnt] = INIT_TABLE[cnt mod 8], resized to DATA_WIDTH (zero-extend if wider, keep LSBs if narrower).
  - cnt increments each cycle. After writing location depth-1, the FSM goes to IDLE.
  - Takes exactly 2**ADDR_WIDTH cycles. ready=0 throughout; req is ignored.
- IDLE, ready=1:
  - req & we: mem[addr] <= wdata at that edge. No rvalid.
  - req & !we & !burst: rdata <= mem[addr] and rvalid=1 on the next cycle, for one cycle only (latency 1).
  - req & !we & burst: latch addr and blen, then go to BURST. ready=0 starting the cycle after acceptance.
  - Back-to-back single reads are allowed every cycle, giving one rvalid per accepted read.
  - A read after a write to the same address returns the new data when the read is issued at least one cycle after the write.
- BURST:
  - Outputs blen+1 consecutive words, one per cycle, with rvalid=1 on each.
  - The first word appears on the cycle after acceptance.
  - Address increments modulo depth: depth-1 wraps to 0.
  - After the last word the FSM returns to IDLE. ready=1 on the cycle the last word is presented, so the next req can be accepted then.
  - req is ignored while ready=0.
- Outside read-data cycles rvalid=0. rdata holds its last value (it is not cleared).
- Address arithmetic: ADDR_WIDTH bits, natural overflow. Burst count: ADDR_WIDTH bits down-counter.

Decomposition:
- Shared package mem_pkg holds:
  - INIT_TABLE: 8 × 8-bit constant = AA, F0, 0F, CC, E7, 18, B7, ED (hex).
  - FSM state enum: INIT, IDLE, BURST.
- One sub-module: sp_ram_sync (DATA_WIDTH, ADDR_WIDTH). Ports: clk, we, addr, wdata, q. It is a registered-read single-port RAM.
- seq_init_ram contains the FSM, init counter, burst address/count registers and port mux in front of sp_ram_sync.

Test Plan:
1. Reset for 2 cycles, release, count cycles → ready rises exactly 8 cycles after reset deasserts. Then single reads of addr 0..7 → rdata = AA, F0, 0F, CC, E7, 18, B7, ED, each one cycle after req with rvalid=1.
2. Write 0x5A to addr 3, then read addr 3 → 0x5A. Read addr 2 → 0x0F, i.e. the neighbour is unchanged.
3. Burst addr=6, blen=3 → four consecutive rvalid cycles with rdata = B7, ED, AA, F0 (wrap from 7 to 0). ready=0 during the first three words and 1 on the last.
4. Assert reset during the second word of a burst → rvalid=0 on the next cycle, ready=0 for 8 cycles. After that, addr 3 reads CC again, because a prior write of 0x5A is overwritten by re-init.
5. Assert req during INIT and during BURST → ignored: no write takes effect and no extra rvalid appears.
6. Rerun scenario 1 with DATA_WIDTH=12, ADDR_WIDTH=4 → init lasts 16 cycles. addr 9 reads 0x0F0 and addr 15 reads 0x0ED (table repeats, zero-extended).
